// File: rtl/rv32i_memaccess_stage.sv
// rtl/rv32i_memaccess_stage.sv - RV32I memory-access stage driving a pipelined Wishbone-style data bus.
// Optional MISALIGN_TRAP_EN: misaligned halfword/word accesses skip the bus and pulse o_misaligned.
module rv32i_memaccess_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_y,
  input  logic [31:0] i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd,
  input  logic        i_wr_rd,
  input  logic        i_rd_valid,
  input  logic        i_ce,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd,
  output logic        o_wr_rd,
  output logic        o_ce,
  output logic        o_stall,
`ifdef MISALIGN_TRAP_EN
  output logic        o_misaligned,
`endif
  output logic        o_bus_err
);

  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t state, state_nxt;

  logic          accept;
  logic          is_mem;
  logic          misaligned;
  logic          bus_req;
  logic          done;
  logic          timeout;
  logic [2:0]    funct3_q;
  logic [1:0]    a_q;
  logic          load_q;
  logic          store_q;
  logic          wr_rd_q;
  logic [4:0]    rd_addr_q;
  logic [CW-1:0] to_cnt;
  logic [3:0]    st_sel;
  logic [31:0]   st_data;
  logic [31:0]   load_val;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign o_stall = i_stall || (state != S_IDLE);
  assign accept  = i_ce && !o_stall;
  assign is_mem  = i_load || i_store;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((i_funct3[1:0] == 2'b01) && i_y[0]) ||
                      (i_funct3[1] && (i_y[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign bus_req = accept && is_mem && !i_flush && !misaligned;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Ack wins over a timeout landing on the same cycle.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: if (bus_req) state_nxt = S_REQ;
      S_REQ: begin
        if (!i_wb_stall) begin
          if (i_wb_ack) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_wb_ack) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if ((ACK_TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // funct3[1:0]: 00 byte, 01 half, 1x word (covers the unlisted encodings).
  always_comb begin
    st_sel  = 4'hF;
    st_data = i_rs2;
    case (i_funct3[1:0])
      2'b00: begin
        st_sel  = 4'b0001 << i_y[1:0];
        st_data = {4{i_rs2[7:0]}};
      end
      2'b01: begin
        st_sel  = i_y[1] ? 4'b1100 : 4'b0011;
        st_data = {2{i_rs2[15:0]}};
      end
      default: begin
        st_sel  = 4'hF;
        st_data = i_rs2;
      end
    endcase
  end

  always_comb begin
    ld_byte = i_wb_data[7:0];
    case (a_q)
      2'd0: ld_byte = i_wb_data[7:0];
      2'd1: ld_byte = i_wb_data[15:8];
      2'd2: ld_byte = i_wb_data[23:16];
      2'd3: ld_byte = i_wb_data[31:24];
      default: ld_byte = i_wb_data[7:0];
    endcase
    ld_half  = a_q[1] ? i_wb_data[31:16] : i_wb_data[15:0];
    load_val = i_wb_data;
    case (funct3_q[1:0])
      2'b00:   load_val = funct3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_val = funct3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_val = i_wb_data;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_addr    <= 32'h0;
      o_wb_data    <= 32'h0;
      o_wb_sel     <= 4'h0;
      o_rd_addr    <= 5'h0;
      o_rd         <= 32'h0;
      o_wr_rd      <= 1'b0;
      o_ce         <= 1'b0;
      o_bus_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      o_misaligned <= 1'b0;
`endif
      funct3_q     <= 3'h0;
      a_q          <= 2'h0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      wr_rd_q      <= 1'b0;
      rd_addr_q    <= 5'h0;
      to_cnt       <= '0;
    end else begin
      o_bus_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      o_misaligned <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            funct3_q  <= i_funct3;
            a_q       <= i_y[1:0];
            load_q    <= i_load;
            store_q   <= i_store;
            wr_rd_q   <= i_wr_rd;
            rd_addr_q <= i_rd_addr;
            if (!is_mem) begin
              o_rd      <= i_rd;
              o_rd_addr <= i_rd_addr;
              o_wr_rd   <= i_wr_rd;
              o_ce      <= !i_flush;
            end else if (bus_req) begin
              o_wb_cyc  <= 1'b1;
              o_wb_stb  <= 1'b1;
              o_wb_we   <= i_store;
              o_wb_addr <= {i_y[31:2], 2'b00};
              o_wb_sel  <= i_store ? st_sel : 4'h0;
              o_wb_data <= i_store ? st_data : 32'h0;
              o_ce      <= 1'b0;
              to_cnt    <= '0;
`ifdef MISALIGN_TRAP_EN
            end else if (misaligned && !i_flush) begin
              o_rd_addr    <= i_rd_addr;
              o_wr_rd      <= 1'b0;
              o_ce         <= 1'b1;
              o_misaligned <= 1'b1;
`endif
            end else begin
              o_ce <= 1'b0;
            end
          end else if (!i_stall) begin
            o_ce <= 1'b0;
          end
        end
        S_REQ, S_WAIT: begin
          o_ce <= 1'b0;
          if ((state == S_REQ) && !i_wb_stall) o_wb_stb <= 1'b0;
          if ((state == S_WAIT) && !done && !timeout) to_cnt <= to_cnt + CW'(1);
          if (done) begin
            o_wb_cyc  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_ce      <= 1'b1;
            o_rd_addr <= rd_addr_q;
            o_wr_rd   <= wr_rd_q && !store_q;
            if (load_q) o_rd <= load_val;
          end
          if (timeout) begin
            o_wb_cyc  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_bus_err <= 1'b1;
          end
        end
        default: begin
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = i_rd_valid;

endmodule
